// File: rtl/proc_io_ctrl.sv
// proc_io_ctrl
//   I/O port controller between the proc_fx core and external sample
//   sources/sinks. Each input and output channel has a single-entry holding
//   register with a full bit. Reads of empty inputs and overwrites of
//   unconsumed outputs raise sticky per-channel flags.
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   proc_req_in/proc_addr_in      core input-read strobe and channel select
//   proc_io_in                    selected input word (combinational)
//   proc_out_en/proc_addr_out     core output-write strobe and channel select
//   proc_io_out                   word written by the core
//   s_data/s_valid/s_ready        input channels (ch k = [k*NUBITS +: NUBITS])
//   m_data/m_valid/m_ready        output channels, same packing
//   underrun/overrun              sticky event flags
//   clr_flags                     clears both flag vectors
module proc_io_ctrl #(
  parameter int unsigned NUBITS = 16,
  parameter int unsigned NUIOIN = 8,
  parameter int unsigned NUIOOU = 8,
  parameter int unsigned NAIN   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  parameter int unsigned NAOU   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [NAIN-1:0]          proc_addr_in,
  output logic [NUBITS-1:0]        proc_io_in,
  input  logic                     proc_out_en,
  input  logic [NAOU-1:0]          proc_addr_out,
  input  logic [NUBITS-1:0]        proc_io_out,
  input  logic [NUIOIN*NUBITS-1:0] s_data,
  input  logic [NUIOIN-1:0]        s_valid,
  output logic [NUIOIN-1:0]        s_ready,
  output logic [NUIOOU*NUBITS-1:0] m_data,
  output logic [NUIOOU-1:0]        m_valid,
  input  logic [NUIOOU-1:0]        m_ready,
  output logic [NUIOIN-1:0]        underrun,
  output logic [NUIOOU-1:0]        overrun,
  input  logic                     clr_flags
);

  logic [NUBITS-1:0] in_reg_q  [NUIOIN];
  logic [NUBITS-1:0] in_reg_d  [NUIOIN];
  logic [NUBITS-1:0] out_reg_q [NUIOOU];
  logic [NUBITS-1:0] out_reg_d [NUIOOU];
  logic [NUIOIN-1:0] in_full_q, in_full_d;
  logic [NUIOOU-1:0] out_full_q, out_full_d;
  logic [NUIOIN-1:0] under_q, under_d;
  logic [NUIOOU-1:0] over_q, over_d;
  logic              rd_addr_ok, wr_addr_ok;

  // Extra bit keeps the range test meaningful for power-of-2 channel counts.
  always_comb begin
    rd_addr_ok = {1'b0, proc_addr_in}  < (NAIN+1)'(NUIOIN);
    wr_addr_ok = {1'b0, proc_addr_out} < (NAOU+1)'(NUIOOU);
  end

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    s_ready    = {NUIOIN{rst}} & ~in_full_q;
    m_valid    = {NUIOOU{rst}} & out_full_q;
    proc_io_in = rd_addr_ok ? in_reg_q[proc_addr_in] : '0;
    underrun   = under_q;
    overrun    = over_q;
    m_data     = '0;
    for (int unsigned j = 0; j < NUIOOU; j++) begin
      m_data[j*NUBITS +: NUBITS] = out_reg_q[j];
    end
  end

  always_comb begin
    logic ld, rd;
    ld = 1'b0;
    rd = 1'b0;
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      ld = s_valid[k] & s_ready[k];
      rd = proc_req_in & rd_addr_ok & (proc_addr_in == NAIN'(k));
      in_reg_d[k]  = ld ? s_data[k*NUBITS +: NUBITS] : in_reg_q[k];
      // A same-cycle load outranks the read's clear.
      in_full_d[k] = ld | (in_full_q[k] & ~rd);
      // A same-cycle event outranks clr_flags.
      under_d[k]   = (under_q[k] & ~clr_flags) | (rd & ~in_full_q[k]);
    end
  end

  always_comb begin
    logic wr, pop;
    wr  = 1'b0;
    pop = 1'b0;
    for (int unsigned j = 0; j < NUIOOU; j++) begin
      wr  = proc_out_en & wr_addr_ok & (proc_addr_out == NAOU'(j));
      pop = m_valid[j] & m_ready[j];
      out_reg_d[j]  = wr ? proc_io_out : out_reg_q[j];
      out_full_d[j] = wr | (out_full_q[j] & ~pop);
      // Writing while the old word is popped is a clean hand-over, not an overrun.
      over_d[j]     = (over_q[j] & ~clr_flags) | (wr & out_full_q[j] & ~pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_full_q  <= '0;
      out_full_q <= '0;
      under_q    <= '0;
      over_q     <= '0;
      for (int unsigned k = 0; k < NUIOIN; k++) in_reg_q[k] <= '0;
      for (int unsigned j = 0; j < NUIOOU; j++) out_reg_q[j] <= '0;
    end else begin
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
      under_q    <= under_d;
      over_q     <= over_d;
      for (int unsigned k = 0; k < NUIOIN; k++) in_reg_q[k] <= in_reg_d[k];
      for (int unsigned j = 0; j < NUIOOU; j++) out_reg_q[j] <= out_reg_d[j];
    end
  end

endmodule
